// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared feature-map geometry and capture-buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int FMAP_H  = 14;
    localparam int FMAP_W  = 14;
    localparam int FMAP_C  = 16;
    localparam int N_TOTAL = FMAP_H * FMAP_W * FMAP_C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/fmap_ram.sv
// ============================================================================
// Module      : fmap_ram
// Description : Simple dual-port frame RAM, one write port, one synchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_ram
    import cnn_pkg::*;
#(
    parameter int DEPTH = N_TOTAL,
    parameter int DW    = 8,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/flatten_capture_buffer.sv
// ============================================================================
// Module      : flatten_capture_buffer
// Description : Captures one contiguous flattened frame, then replays it on a
//               valid/ready stream through a two-entry skid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flatten_capture_buffer #(
    parameter int N_TOTAL = cnn_pkg::N_TOTAL,
    parameter int DW      = 8,
    parameter int AW      = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] in_idx,
    input  logic          in_frame_done,
    input  logic          clr_err,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] rd_idx,
    output logic          rd_last,
    output logic          buf_full,
    output logic          err_seq,
    output logic          err_ovf
);
    import cnn_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_TOTAL - 1);
    localparam logic [AW:0]   RD_END   = (AW+1)'(N_TOTAL);

    cap_state_t    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflight_idx_q, inflight_idx_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic [AW-1:0] skid_idx_q, skid_idx_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          err_seq_q, err_seq_d;
    logic          err_ovf_q, err_ovf_d;

    logic          acc, wr_en, rd_en, pop, seq_set, ovf_set;
    logic [1:0]    occ;
    logic [DW-1:0] ram_data;

    assign acc = en && in_valid;
    assign pop = out_valid_q && rd_ready;
    assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};

    fmap_ram #(.DEPTH(N_TOTAL), .DW(DW), .AW(AW)) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (in_idx),
        .wr_data_i (din),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (ram_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        seq_set  = 1'b0;
        ovf_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (in_idx == '0) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = AW'(1);
                        state_d  = FILL;
                    end else begin
                        seq_set = 1'b1;
                    end
                end
            end
            FILL: begin
                if (acc) begin
                    if (in_idx != wr_ptr_q) begin
                        seq_set  = 1'b1;
                        wr_ptr_d = '0;
                        state_d  = IDLE;
                    end else begin
                        wr_en = 1'b1;
                        if (in_idx == LAST_IDX) begin
                            wr_ptr_d = '0;
                            state_d  = in_frame_done ? FULL : IDLE;
                            seq_set  = !in_frame_done;
                        end else if (in_frame_done) begin
                            seq_set  = 1'b1;
                            wr_ptr_d = '0;
                            state_d  = IDLE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
            end
            FULL: begin
                ovf_set  = acc;
                rd_en    = 1'b1;
                rd_ptr_d = (AW+1)'(1);
                state_d  = DRAIN;
            end
            DRAIN: begin
                ovf_set = acc;
                // Issue only if the read cannot overflow output reg + skid.
                if (rd_ptr_q != RD_END && (occ < 2'd2 || pop)) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (pop && out_last_q) begin
                    rd_ptr_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d     = rd_en;
        inflight_idx_d = rd_ptr_q[AW-1:0];
        skid_valid_d   = skid_valid_q;
        skid_data_d    = skid_data_q;
        skid_idx_d     = skid_idx_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_idx_d      = out_idx_q;
        out_last_d     = out_last_q;
        if (!out_valid_q || rd_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_idx_d    = skid_idx_q;
                out_last_d   = (skid_idx_q == LAST_IDX);
                skid_valid_d = inflight_q;
                skid_data_d  = ram_data;
                skid_idx_d   = inflight_idx_q;
            end else if (inflight_q) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_data;
                out_idx_d   = inflight_idx_q;
                out_last_d  = (inflight_idx_q == LAST_IDX);
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ram_data;
            skid_idx_d   = inflight_idx_q;
        end
        err_seq_d = seq_set || (err_seq_q && !clr_err);
        err_ovf_d = ovf_set || (err_ovf_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            skid_valid_q   <= 1'b0;
            skid_data_q    <= '0;
            skid_idx_q     <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_idx_q      <= '0;
            out_last_q     <= 1'b0;
            err_seq_q      <= 1'b0;
            err_ovf_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            skid_valid_q   <= skid_valid_d;
            skid_data_q    <= skid_data_d;
            skid_idx_q     <= skid_idx_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_idx_q      <= out_idx_d;
            out_last_q     <= out_last_d;
            err_seq_q      <= err_seq_d;
            err_ovf_q      <= err_ovf_d;
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
    assign rd_idx   = out_idx_q;
    assign rd_last  = out_last_q;
    assign buf_full = (state_q == FULL) || (state_q == DRAIN);
    assign err_seq  = err_seq_q;
    assign err_ovf  = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_flatten_capture_buffer.sv
// ============================================================================
// Module      : tb_flatten_capture_buffer
// Description : Randomized self-checking bench for flatten_capture_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flatten_capture_buffer;

    localparam int N  = 3136;
    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] in_idx = '0;
    logic          in_frame_done = 1'b0;
    logic          clr_err = 1'b0;
    logic          rd_ready = 1'b1;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_idx;
    logic          rd_last;
    logic          buf_full;
    logic          err_seq;
    logic          err_ovf;

    flatten_capture_buffer #(.N_TOTAL(N), .DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .in_valid      (in_valid),
        .din           (din),
        .in_idx        (in_idx),
        .in_frame_done (in_frame_done),
        .clr_err       (clr_err),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_idx        (rd_idx),
        .rd_last       (rd_last),
        .buf_full      (buf_full),
        .err_seq       (err_seq),
        .err_ovf       (err_ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference frame: the bytes the stream must reproduce, in index order.
    logic [DW-1:0] exp_mem  [N];
    logic [DW-1:0] got_data [N];
    logic [AW-1:0] got_idx  [N];
    logic          got_last [N];
    int            got_n, stall_viol, cycles_used;
    bit            timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_model(input bit idx_pattern);
        for (int i = 0; i < N; i++) exp_mem[i] = idx_pattern ? 8'(i) : 8'($urandom);
    endtask

    task automatic send_range(input int first, input int last, input int done_at);
        for (int i = first; i <= last; i++) begin
            en            = 1'b1;
            in_valid      = 1'b1;
            din           = exp_mem[i];
            in_idx        = AW'(i);
            in_frame_done = (i == done_at);
            tick();
        end
        in_valid      = 1'b0;
        in_frame_done = 1'b0;
        in_idx        = '0;
        din           = '0;
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Records every handshake and any output change while stalled.
    task automatic collect(input int ready_pct, input int max_bytes);
        logic          ps, pl;
        logic [DW-1:0] pd;
        logic [AW-1:0] pi;
        int            cyc;
        got_n = 0; stall_viol = 0; timed_out = 0; ps = 0; cyc = 0;
        pl = 0; pd = '0; pi = '0;
        while (got_n < max_bytes) begin
            if (cyc > 8 * N) begin
                timed_out = 1;
                break;
            end
            rd_ready = ($urandom_range(99) < ready_pct);
            if (ps && (rd_valid !== 1'b1 || rd_data !== pd || rd_idx !== pi || rd_last !== pl))
                stall_viol++;
            if (rd_valid === 1'b1 && rd_ready) begin
                got_data[got_n] = rd_data;
                got_idx[got_n]  = rd_idx;
                got_last[got_n] = rd_last;
                got_n++;
            end
            ps = (rd_valid === 1'b1) && !rd_ready;
            pd = rd_data; pi = rd_idx; pl = rd_last;
            tick();
            cyc++;
        end
        cycles_used = cyc;
        rd_ready = 1'b1;
    endtask

    function automatic int frame_errors();
        int bad = 0;
        for (int k = 0; k < N; k++)
            if (got_data[k] !== exp_mem[k] || got_idx[k] !== AW'(k) || got_last[k] !== (k == N - 1))
                bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_vec++;
        if ({rd_valid, rd_last, buf_full, err_seq, err_ovf} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, want 00000", {rd_valid, rd_last, buf_full, err_seq, err_ovf});
        end
        n_vec++;
        if (rd_data !== '0 || rd_idx !== '0) begin
            n_err++;
            $display("FAIL reset_data: got data %0h idx %0d, want 0 0", rd_data, rd_idx);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int bad;
        fill_model(1'b1);
        rd_ready = 1'b1;
        send_range(0, N - 1, N - 1);
        n_vec++;
        if (buf_full !== 1'b1 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL nominal_full_at_E: got full=%b valid=%b, want 1 0", buf_full, rd_valid);
        end
        tick();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL nominal_valid_at_E1: got %b, want 0", rd_valid);
        end
        tick();
        n_vec++;
        if (rd_valid !== 1'b1 || rd_idx !== '0 || rd_data !== exp_mem[0]) begin
            n_err++;
            $display("FAIL nominal_first_byte: got valid=%b idx=%0d data=%0h, want 1 0 %0h",
                     rd_valid, rd_idx, rd_data, exp_mem[0]);
        end
        collect(100, N);
        bad = frame_errors();
        n_vec++;
        if (got_n != N || bad != 0) begin
            n_err++;
            $display("FAIL nominal_bytes: got %0d bytes %0d bad, want %0d bytes 0 bad", got_n, bad, N);
        end
        n_vec++;
        if (cycles_used != N) begin
            n_err++;
            $display("FAIL nominal_throughput: got %0d cycles, want %0d", cycles_used, N);
        end
        n_vec++;
        if ({buf_full, rd_valid, err_seq, err_ovf} !== 4'b0) begin
            n_err++;
            $display("FAIL nominal_idle_after: got full/valid/seq/ovf=%b, want 0000",
                     {buf_full, rd_valid, err_seq, err_ovf});
        end
    endtask

    task automatic test_backpressure();
        int bad;
        fill_model(1'b0);
        send_range(0, N - 1, N - 1);
        collect(50, N);
        bad = frame_errors();
        n_vec++;
        if (got_n != N || bad != 0 || timed_out) begin
            n_err++;
            $display("FAIL bp_bytes: got %0d bytes %0d bad timeout=%0d, want %0d 0 0", got_n, bad, timed_out, N);
        end
        n_vec++;
        if (stall_viol != 0) begin
            n_err++;
            $display("FAIL bp_stall_stable: got %0d unstable stalls, want 0", stall_viol);
        end
        n_vec++;
        if (buf_full !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle_after: got full=%b valid=%b, want 0 0", buf_full, rd_valid);
        end
    endtask

    task automatic test_index_skip();
        int bad;
        fill_model(1'b0);
        send_range(0, 99, -1);
        send_range(101, 101, -1);
        n_vec++;
        if (err_seq !== 1'b1 || buf_full !== 1'b0) begin
            n_err++;
            $display("FAIL skip_err: got seq=%b full=%b, want 1 0", err_seq, buf_full);
        end
        repeat (5) tick();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skip_no_output: got valid=%b, want 0", rd_valid);
        end
        // New error in the same cycle as clr_err must keep the flag set.
        en = 1'b1; in_valid = 1'b1; in_idx = AW'(7); clr_err = 1'b1;
        tick();
        in_valid = 1'b0; in_idx = '0; clr_err = 1'b0;
        n_vec++;
        if (err_seq !== 1'b1) begin
            n_err++;
            $display("FAIL clr_vs_set: got err_seq=%b, want 1", err_seq);
        end
        clear_errors();
        n_vec++;
        if (err_seq !== 1'b0) begin
            n_err++;
            $display("FAIL skip_clear: got err_seq=%b, want 0", err_seq);
        end
        send_range(0, N - 1, N - 1);
        collect(100, N);
        bad = frame_errors();
        n_vec++;
        if (got_n != N || bad != 0) begin
            n_err++;
            $display("FAIL skip_recover: got %0d bytes %0d bad, want %0d 0", got_n, bad, N);
        end
    endtask

    task automatic test_framing();
        fill_model(1'b0);
        send_range(0, 500, 500);
        n_vec++;
        if (err_seq !== 1'b1 || buf_full !== 1'b0) begin
            n_err++;
            $display("FAIL early_done: got seq=%b full=%b, want 1 0", err_seq, buf_full);
        end
        clear_errors();
        send_range(0, N - 1, -1);
        repeat (3) tick();
        n_vec++;
        if (err_seq !== 1'b1 || buf_full !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL missing_done: got seq=%b full=%b valid=%b, want 1 0 0", err_seq, buf_full, rd_valid);
        end
        clear_errors();
    endtask

    task automatic test_overrun();
        int bad;
        fill_model(1'b0);
        send_range(0, N - 1, N - 1);
        fork
            collect(100, N);
            begin
                repeat (20) tick();
                en = 1'b1; in_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    in_idx = AW'(i); din = 8'($urandom);
                    tick();
                end
                in_valid = 1'b0; in_idx = '0;
            end
        join
        bad = frame_errors();
        n_vec++;
        if (got_n != N || bad != 0) begin
            n_err++;
            $display("FAIL ovf_frame: got %0d bytes %0d bad, want %0d 0", got_n, bad, N);
        end
        n_vec++;
        if (err_ovf !== 1'b1 || err_seq !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_flags: got ovf=%b seq=%b, want 1 0", err_ovf, err_seq);
        end
        clear_errors();
        n_vec++;
        if (err_ovf !== 1'b0 || err_seq !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got ovf=%b seq=%b, want 0 0", err_ovf, err_seq);
        end
    endtask

    task automatic test_reset_drain_and_enable();
        int bad;
        fill_model(1'b0);
        send_range(0, N - 1, N - 1);
        collect(100, 1000);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rd_valid, rd_last, buf_full, err_seq, err_ovf} !== 5'b0 || rd_data !== '0 || rd_idx !== '0) begin
            n_err++;
            $display("FAIL reset_mid_drain: got flags=%b data=%0h idx=%0d, want 0",
                     {rd_valid, rd_last, buf_full, err_seq, err_ovf}, rd_data, rd_idx);
        end
        tick();
        rst_n = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid      = ($urandom_range(3) != 0);
            in_idx        = ($urandom_range(1) != 0) ? AW'(i) : AW'($urandom_range(N - 1));
            din           = 8'($urandom);
            in_frame_done = (i == N - 1);
            tick();
        end
        in_valid = 1'b0; in_frame_done = 1'b0; in_idx = '0;
        repeat (5) tick();
        n_vec++;
        if ({buf_full, rd_valid, err_seq, err_ovf} !== 4'b0) begin
            n_err++;
            $display("FAIL enable_gating: got full/valid/seq/ovf=%b, want 0000", {buf_full, rd_valid, err_seq, err_ovf});
        end
        send_range(0, N - 1, N - 1);
        collect(100, N);
        bad = frame_errors();
        n_vec++;
        if (got_n != N || bad != 0) begin
            n_err++;
            $display("FAIL post_reset_frame: got %0d bytes %0d bad, want %0d 0", got_n, bad, N);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_index_skip();
        test_framing();
        test_overrun();
        test_reset_drain_and_enable();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
